// File: rtl/frame_loader.sv
// Serial-to-parallel frame loader: assembles a burst of words into frame registers and
// issues a one-cycle write to the register-window file when the burst commits.

module frame_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (clear) q <= '0;
  end
endmodule

module frame_loader #(
  parameter int DATA_W       = 32,
  parameter int NUM_FRAMES   = 16,
  parameter int SMALL_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              mode_in,
  input  logic              flush,
  output logic [DATA_W-1:0] frame_0_out,
  output logic [DATA_W-1:0] frame_1_out,
  output logic [DATA_W-1:0] frame_2_out,
  output logic [DATA_W-1:0] frame_3_out,
  output logic [DATA_W-1:0] frame_4_out,
  output logic [DATA_W-1:0] frame_5_out,
  output logic [DATA_W-1:0] frame_6_out,
  output logic [DATA_W-1:0] frame_7_out,
  output logic [DATA_W-1:0] frame_8_out,
  output logic [DATA_W-1:0] frame_9_out,
  output logic [DATA_W-1:0] frame_10_out,
  output logic [DATA_W-1:0] frame_11_out,
  output logic [DATA_W-1:0] frame_12_out,
  output logic [DATA_W-1:0] frame_13_out,
  output logic [DATA_W-1:0] frame_14_out,
  output logic [DATA_W-1:0] frame_15_out,
  output logic              Small_or_Big,
  output logic              write,
  output logic              busy,
  output logic [7:0]        commit_cnt
);
  localparam int CNT_W = 5;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]                         state;
  logic [CNT_W-1:0]                   count;
  logic [CNT_W-1:0]                   limit;
  logic                               accept;
  logic                               first;
  logic                               last;
  logic [NUM_FRAMES-1:0]              lane_ld;
  logic [NUM_FRAMES-1:0][DATA_W-1:0]  frames;

  assign in_ready = ~rst & ((state == S_IDLE) | (state == S_FILL));
  assign accept   = in_valid & in_ready;
  assign first    = accept & (state == S_IDLE);
  assign limit    = Small_or_Big ? CNT_W'(SMALL_FRAMES) : CNT_W'(NUM_FRAMES);
  assign last     = accept & (state == S_FILL) & (count == limit - CNT_W'(1));
  assign write    = (state == S_COMMIT);
  assign busy     = (state == S_FILL) | (state == S_COMMIT);

  // count is 0 in IDLE, so "slot == count" also steers the first word into frame 0;
  // a load wins over the burst-start clear in that slot.
  for (genvar i = 0; i < NUM_FRAMES; i++) begin : g_lane
    localparam logic [CNT_W-1:0] IDX = CNT_W'(i);
    assign lane_ld[i] = accept & (count == IDX);
    frame_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (lane_ld[i]),
      .clear (first),
      .din   (in_data),
      .q     (frames[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      Small_or_Big <= 1'b1;
      commit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            Small_or_Big <= mode_in;
            count        <= CNT_W'(1);
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) count <= count + CNT_W'(1);
          if (last || flush) state <= S_COMMIT;
        end
        S_COMMIT: begin
          commit_cnt <= commit_cnt + 8'd1;
          count      <= '0;
          state      <= S_IDLE;
        end
        default: begin
          count <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign frame_0_out  = frames[0];
  assign frame_1_out  = frames[1];
  assign frame_2_out  = frames[2];
  assign frame_3_out  = frames[3];
  assign frame_4_out  = frames[4];
  assign frame_5_out  = frames[5];
  assign frame_6_out  = frames[6];
  assign frame_7_out  = frames[7];
  assign frame_8_out  = frames[8];
  assign frame_9_out  = frames[9];
  assign frame_10_out = frames[10];
  assign frame_11_out = frames[11];
  assign frame_12_out = frames[12];
  assign frame_13_out = frames[13];
  assign frame_14_out = frames[14];
  assign frame_15_out = frames[15];
endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: a per-cycle vector table for a small burst plus
// hand-written sequences for reset, big/flush bursts, backpressure and counter wrap.

module tb_frame_loader;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic               mode_in;
  logic               flush;
  logic [15:0][31:0]  fr;
  logic               sob;
  logic               write;
  logic               busy;
  logic [7:0]         commit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int nwr   = 0;

  frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mode_in      (mode_in),
    .flush        (flush),
    .frame_0_out  (fr[0]),
    .frame_1_out  (fr[1]),
    .frame_2_out  (fr[2]),
    .frame_3_out  (fr[3]),
    .frame_4_out  (fr[4]),
    .frame_5_out  (fr[5]),
    .frame_6_out  (fr[6]),
    .frame_7_out  (fr[7]),
    .frame_8_out  (fr[8]),
    .frame_9_out  (fr[9]),
    .frame_10_out (fr[10]),
    .frame_11_out (fr[11]),
    .frame_12_out (fr[12]),
    .frame_13_out (fr[13]),
    .frame_14_out (fr[14]),
    .frame_15_out (fr[15]),
    .Small_or_Big (sob),
    .write        (write),
    .busy         (busy),
    .commit_cnt   (commit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write) nwr <= nwr + 1;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        m;
    logic        f;
    logic        rdy;
    logic        wr;
    logic        bsy;
    logic        sob;
    logic        cc;
    logic [7:0]  cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_frames(input string tag, input logic [15:0][31:0] exp);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_frame%0d", tag, i), fr[i], exp[i]);
  endtask

  // Offer one word at the falling edge and hold it until a rising edge accepts it.
  task automatic send(input logic [31:0] d, input logic m, input logic f);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; mode_in = m; flush = f;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1;
    in_valid = 1'b0; flush = 1'b0;
    if (!ok) chk($sformatf("send_ready_%h", d), 32'(ok), 32'd1);
  endtask

  // One word in small mode, then a bare flush; returns just after the commit finishes.
  task automatic commit_one(input logic [31:0] d);
    send(d, 1'b1, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t              tbl[12];
    logic [15:0][31:0] ef;
    int                base;

    tbl[0] = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
    for (int i = 2; i < 8; i++)
      tbl[i] = '{1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[8]  = '{1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_in = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Async reset in the middle of a partially filled big burst
    send(32'h11, 1'b0, 1'b0);
    send(32'h22, 1'b0, 1'b0);
    send(32'h33, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sob", 32'(sob), 32'd1);
    chk("rst_cnt", 32'(commit_cnt), 32'd0);
    chk_frames("rst", '0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Big burst back-to-back
    base = nwr;
    for (int n = 0; n < 16; n++) send(32'h100 + 32'(n), 1'b0, 1'b0);
    chk("big_write", 32'(write), 32'd1);
    chk("big_ready_in_commit", 32'(in_ready), 32'd0);
    chk("big_sob", 32'(sob), 32'd0);
    for (int n = 0; n < 16; n++) ef[n] = 32'h100 + 32'(n);
    chk_frames("big", ef);
    @(posedge clk); #1;
    chk("big_write_off", 32'(write), 32'd0);
    chk("big_ready_back", 32'(in_ready), 32'd1);
    chk("big_busy_off", 32'(busy), 32'd0);
    chk("big_cnt", 32'(commit_cnt), 32'd1);
    chk("big_nwr", 32'(nwr - base), 32'd1);

    // Small burst, per-cycle vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; mode_in = tbl[i].m; flush = tbl[i].f;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_write", i), 32'(write), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_sob", i), 32'(sob), 32'(tbl[i].sob));
      if (tbl[i].cc) chk($sformatf("tbl%0d_cnt", i), 32'(commit_cnt), 32'(tbl[i].cnt));
    end
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    ef = '0;
    for (int n = 0; n < 8; n++) ef[n] = 32'hA0 + 32'(n);
    chk_frames("small", ef);

    // Flush committed together with the 6th word
    for (int n = 0; n < 5; n++) send(32'h200 + 32'(n), 1'b0, 1'b0);
    send(32'h205, 1'b0, 1'b1);
    chk("flush_write", 32'(write), 32'd1);
    chk("flush_sob", 32'(sob), 32'd0);
    ef = '0;
    for (int n = 0; n < 6; n++) ef[n] = 32'h200 + 32'(n);
    chk_frames("flush", ef);
    @(posedge clk); #1;
    chk("flush_cnt", 32'(commit_cnt), 32'd3);

    // Random gaps, then the next burst offered while the previous one commits
    base = nwr;
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(32'h300 + 32'(n), 1'b0, 1'b0);
    end
    chk("bp_write", 32'(write), 32'd1);
    chk("bp_ready_in_commit", 32'(in_ready), 32'd0);
    for (int n = 0; n < 16; n++) ef[n] = 32'h300 + 32'(n);
    chk_frames("bp_big", ef);
    for (int n = 0; n < 8; n++) begin
      send(32'h400 + 32'(n), 1'b1, 1'b0);
      if (n < 7) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    chk("bp_small_write", 32'(write), 32'd1);
    chk("bp_small_sob", 32'(sob), 32'd1);
    ef = '0;
    for (int n = 0; n < 8; n++) ef[n] = 32'h400 + 32'(n);
    chk_frames("bp_small", ef);
    @(posedge clk); #1;
    chk("bp_nwr", 32'(nwr - base), 32'd2);
    chk("bp_cnt", 32'(commit_cnt), 32'd5);

    // Reset after 7 words, then a clean big burst
    for (int n = 0; n < 7; n++) send(32'h500 + 32'(n), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(commit_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;
    base = nwr;
    for (int n = 0; n < 16; n++) send(32'h600 + 32'(n), 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) ef[n] = 32'h600 + 32'(n);
    chk_frames("after_rst", ef);
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_nwr", 32'(nwr - base), 32'd1);
    chk("after_rst_cnt", 32'(commit_cnt), 32'd1);

    // Counter wrap
    for (int n = 0; n < 254; n++) commit_one(32'h700 + 32'(n));
    chk("cnt_255", 32'(commit_cnt), 32'd255);
    commit_one(32'hBEEF);
    chk("cnt_wrap", 32'(commit_cnt), 32'd0);
    chk("wrap_frame0", fr[0], 32'hBEEF);
    chk("wrap_frame1", fr[1], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
